// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: shared constants and types for the SPI PWM register bank
package spi_pwm_pkg;
  localparam int REG_W = 16;
  localparam int RW_BIT = 7;
  localparam int ADDR_MSB = 3;
  localparam logic [ADDR_MSB:0] ADDR_PERIOD = 4'hF;
  localparam logic [1:0] S_CMD = 2'd0;
  localparam logic [1:0] S_HI = 2'd1;
  localparam logic [1:0] S_LO = 2'd2;
  typedef logic [REG_W-1:0] reg_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output whose duty shadow reloads only when the shared counter wraps
module pwm_channel
  import spi_pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  reg_t duty_i,
  input  logic wrap_i,
  input  reg_t cnt_i,
  output logic pwm_o
);
  reg_t duty_sh_q;
  logic pwm_q;
  assign pwm_o = pwm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      duty_sh_q <= wrap_i ? duty_i : duty_sh_q;
      pwm_q <= cnt_i < duty_sh_q;
    end
  end
endmodule

// File: rtl/spi_pwm_regs.sv
// spi_pwm_regs: 3-byte SPI frame decoder, PWM register bank and PWM generator; define SPI_READBACK_EN for register readback on tx_byte
module spi_pwm_regs
  import spi_pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter logic [15:0] PERIOD_RST = 16'hFFFF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cmd_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_MSB:0] NCH = 4'(NUM_CH);
  logic [1:0] state_q, state_d;
  logic rw_q, rw_d, wr, err_q, err_d, wrap;
  logic [ADDR_MSB:0] addr_q, addr_d, rx_addr;
  logic [7:0] hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  reg_t duty_q [NUM_CH];
  reg_t period_q, period_sh_q, cnt_q;

  function automatic logic addr_ok(input logic [ADDR_MSB:0] a);
    return a < NCH || a == ADDR_PERIOD;
  endfunction

  assign rx_addr = rx_byte[ADDR_MSB:0];
  assign wrap = cnt_q == period_sh_q;
  assign cmd_err = err_q;

  // Framing is by byte count only; the timeout counter runs while a frame is open
  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    addr_d = addr_q;
    hi_d = hi_q;
    tmo_d = '0;
    err_d = 1'b0;
    wr = 1'b0;
    if (state_q == S_CMD) begin
      if (rx_valid) begin
        state_d = S_HI;
        rw_d = rx_byte[RW_BIT];
        addr_d = rx_addr;
        err_d = !addr_ok(rx_addr);
      end
    end else if (rx_valid) begin
      state_d = state_q == S_HI ? S_LO : S_CMD;
      hi_d = state_q == S_HI ? rx_byte : hi_q;
      wr = state_q == S_LO && !rw_q && addr_ok(addr_q);
    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = S_CMD;
      err_d = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_CMD;
      rw_q <= 1'b0;
      addr_q <= '0;
      hi_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      period_q <= PERIOD_RST;
      period_sh_q <= PERIOD_RST;
      cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      hi_q <= hi_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      period_sh_q <= wrap ? period_q : period_sh_q;
      if (wr && addr_q == ADDR_PERIOD) period_q <= {hi_q, rx_byte};
      for (int i = 0; i < NUM_CH; i++) if (wr && addr_q == 4'(i)) duty_q[i] <= {hi_q, rx_byte};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_channel u_ch (
      .clk   (sys_clk),
      .rst   (rst),
      .duty_i(duty_q[c]),
      .wrap_i(wrap),
      .cnt_i (cnt_q),
      .pwm_o (pwm_out[c])
    );
  end

`ifdef SPI_READBACK_EN
  reg_t sel, rd_q, rd_d;
  logic [7:0] tx_q, tx_d;
  // Whole register is captured at the cmd byte so hi and lo always belong together
  always_comb begin
    sel = rx_addr == ADDR_PERIOD ? period_q : '0;
    for (int i = 0; i < NUM_CH; i++) sel = rx_addr == 4'(i) ? duty_q[i] : sel;
  end
  always_comb begin
    rd_d = state_q == S_CMD && rx_valid ? sel : rd_q;
    tx_d = state_d == S_CMD ? 8'h00 : !rx_valid ? tx_q :
           state_q == S_CMD ? (rx_byte[RW_BIT] ? rd_d[15:8] : 8'h00) :
           (rw_q ? rd_q[7:0] : 8'h00);
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rd_q <= '0;
      tx_q <= 8'h00;
    end else begin
      rd_q <= rd_d;
      tx_q <= tx_d;
    end
  end
  assign tx_byte = tx_q;
`else
  assign tx_byte = 8'h00;
`endif
endmodule

// File: tb/tb_spi_pwm_regs.sv
// tb_spi_pwm_regs: directed frames with a scoreboard of per-byte tx_byte/cmd_err expectations plus PWM waveform checks
module tb_spi_pwm_regs;
  localparam int NUM_CH = 4;
  localparam int TMO = 40;
  localparam logic [15:0] PRST = 16'h0031;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    string name;
    logic [7:0] tx;
    logic err;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, rxd = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic [NUM_CH-1:0] pwm_out;
  logic cmd_err;
  int checks = 0, errors = 0;
  exp_t sb[$];

  spi_pwm_regs #(.NUM_CH(NUM_CH), .PERIOD_RST(PRST), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .tx_byte (tx_byte),
    .pwm_out (pwm_out),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rxd <= rx_valid;

  function automatic logic [7:0] rb(input logic [7:0] v);
    return RB ? v : 8'h00;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rxd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got a consumed byte, expected none pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_tx"}, 16'(tx_byte), 16'(e.tx));
        check({e.name, "_err"}, 16'(cmd_err), 16'(e.err));
      end
    end
  end

  task automatic send(input string name, input logic [7:0] b, input logic [7:0] tx, input logic err);
    repeat (2) @(posedge clk);
    #1;
    rx_byte = b;
    rx_valid = 1'b1;
    sb.push_back('{name, tx, err});
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic frame(input string name, input logic [7:0] b0, b1, b2,
                       input logic [7:0] t0, t1, input logic e0);
    send({name, "0"}, b0, t0, e0);
    send({name, "1"}, b1, t1, 1'b0);
    send({name, "2"}, b2, 8'h00, 1'b0);
  endtask

  task automatic measure(input int ch, output int highs, output int span);
    logic p;
    int n;
    highs = 0;
    span = 0;
    @(negedge clk);
    p = pwm_out[ch];
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (pwm_out[ch] && !p) break;
      p = pwm_out[ch];
    end
    if (n == 500) return;
    for (n = 1; n < 500; n++) begin
      highs += int'(pwm_out[ch]);
      p = pwm_out[ch];
      @(negedge clk);
      if (pwm_out[ch] && !p) begin
        span = n;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, sp, pulses, first;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 16'(tx_byte), 16'h0);
    check("rst_err", 16'(cmd_err), 16'h0);
    check("rst_pwm", 16'(pwm_out), 16'h0);
    #1 rst = 1'b0;
    // 1) write duty0 = 0x0808; exceeds period, so output goes constant 1 after a wrap
    frame("t1_wr", 8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("t1_pwm0_before_wrap", 16'(pwm_out[0]), 16'h0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t1_pwm0_after_wrap", 16'(pwm_out[0]), 16'h1);
    // 2) read back ch0
    frame("t2_rd", 8'h80, 8'h00, 8'h00, rb(8'h08), rb(8'h08), 1'b0);
    // 3) period 9, duty1 3 -> 3 high of every 10
    frame("t3_per", 8'h0F, 8'h00, 8'h09, 8'h00, 8'h00, 1'b0);
    frame("t3_d1", 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 1'b0);
    repeat (120) @(posedge clk);
    measure(1, hi, sp);
    check("t3_pwm1_highs", 16'(hi), 16'd3);
    check("t3_pwm1_period", 16'(sp), 16'd10);
    @(negedge clk);
    check("t3_pwm0_const1", 16'(pwm_out[0]), 16'h1);
    // 4) abandoned frame times out, then a full write lands
    send("t4_a", 8'h00, 8'h00, 1'b0);
    send("t4_b", 8'h12, 8'h00, 1'b0);
    pulses = 0;
    first = -1;
    for (int i = 0; i < TMO + 10; i++) begin
      @(negedge clk);
      if (cmd_err) begin
        pulses++;
        first = i;
      end
    end
    check("t4_tmo_pulses", 16'(pulses), 16'd1);
    check("t4_tmo_when", 16'(first >= TMO - 1 && first <= TMO + 1), 16'h1);
    check("t4_tmo_tx", 16'(tx_byte), 16'h0);
    frame("t4_rd_keep", 8'h80, 8'h00, 8'h00, rb(8'h08), rb(8'h08), 1'b0);
    frame("t4_wr", 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 1'b0);
    frame("t4_rd_new", 8'h80, 8'h00, 8'h00, rb(8'h00), rb(8'h05), 1'b0);
    repeat (30) @(posedge clk);
    measure(0, hi, sp);
    check("t4_pwm0_highs", 16'(hi), 16'd5);
    check("t4_pwm0_period", 16'(sp), 16'd10);
    // 5) invalid address: error pulse, nothing written
    frame("t5_bad_wr", 8'h07, 8'hAA, 8'hBB, 8'h00, 8'h00, 1'b1);
    frame("t5_bad_rd", 8'h87, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    frame("t5_rd3", 8'h83, 8'h00, 8'h00, rb(8'h00), rb(8'h00), 1'b0);
    frame("t5_rd1", 8'h81, 8'h00, 8'h00, rb(8'h00), rb(8'h03), 1'b0);
    frame("t5_rdp", 8'h8F, 8'h00, 8'h00, rb(8'h00), rb(8'h09), 1'b0);
    // 6) reset mid-frame
    send("t6_a", 8'h00, 8'h00, 1'b0);
    send("t6_b", 8'h11, 8'h00, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_pwm", 16'(pwm_out), 16'h0);
    check("t6_tx", 16'(tx_byte), 16'h0);
    check("t6_err", 16'(cmd_err), 16'h0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t6_pwm_duty0", 16'(pwm_out), 16'h0);
    frame("t6_rdp", 8'h8F, 8'h00, 8'h00, rb(PRST[15:8]), rb(PRST[7:0]), 1'b0);
    frame("t6_rd0", 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    frame("t6_wr2", 8'h02, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0);
    frame("t6_rd2", 8'h82, 8'h00, 8'h00, rb(8'h12), rb(8'h34), 1'b0);
    repeat (3) @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
